video_stream_capture: RTL and testbench
=======================================

// Module: video_stream_capture
// PURPOSE
//  AXI4-Stream video slave; inverse of the frame-buffer video stream generator.
//  Accepts 32-bit RGB pixels with tuser = SOF and tlast = EOL.
//  Decodes each pixel to a signed fixed-point value and writes it into
//  per-column frame memories at the current row address.
//  Sits between a video DMA/test source and the column-organised compute arrays.
// PARAMETERS
//  PIXEL_BITDEPTH         16   width of signed fixed-point sample written to memory
//  PIXEL_FRACTIONAL_SIZE  8    fractional bits of sample (+1.0 = 1<<PIXEL_FRACTIONAL_SIZE)
//  IMAGE_COLUMNS          160  pixels per line = number of column memories
//  IMAGE_ROWS             160  lines per frame = depth of each column memory
// PORTS
//  clk_i               in   1    clock; also the AXIS clock
//  rst_ni              in   1    asynchronous, active-low reset
//  s00_axis_tvalid     in   1    pixel valid
//  s00_axis_tdata      in   32   {2'b0,C2[7:0],2'b0,C1[7:0],2'b0,C0[7:0],2'b0}
//  s00_axis_tlast      in   1    end of line
//  s00_axis_tuser      in   1    start of frame
//  s00_axis_tready     out  1    slave ready
//  mem_write_en_o      out  IMAGE_COLUMNS  one-hot write strobe, bit = column
//  mem_write_address_o out  clogb2(IMAGE_ROWS-1)  row address, shared by all columns
//  mem_write_data_o    out  PIXEL_BITDEPTH  signed sample, shared by all columns
//  frame_done_o        out  1    1-cycle pulse: last pixel of a complete frame written
//  sync_error_o        out  1    1-cycle pulse: framing violation detected
// BEHAVIOUR
//  Reset: all outputs 0 (tready 0); state IDLE; row/col counters 0.
//  tready = 1 in every state after reset; it is never deasserted for back-pressure.
//  A beat is accepted when tvalid & tready.
//  Decode, C2 = tdata[29:22], C1 = tdata[19:12]:
//   - C1 >= 8'h80                -> +1.0 ({0..,1,FRAC zeros})
//   - else C2 >= 8'h80           -> -1.0 ({ones,FRAC zeros})
//   - else                       -> 0
//   - Round-trips the generator's white/blue/black encoding exactly.
//  Latency: accepted beat -> write strobe + data + address on the next clk edge (registered).
//   - Without an accepted beat, mem_write_en_o is 0 for that cycle.
//  FSM IDLE: beats without tuser are dropped, no write, no error.
//   - Beat with tuser: write at row 0, col 0; col := 1; -> CAPTURE.
//  FSM CAPTURE, per accepted beat:
//   - tuser=1 (mid-frame SOF): pulse sync_error; restart the frame with this beat at row 0, col 0.
//   - tlast=1 with col < IMAGE_COLUMNS-1 (early EOL): write the beat; pulse sync_error; -> IDLE.
//   - col == IMAGE_COLUMNS-1 with tlast=0 (late EOL): write the beat; pulse sync_error; -> IDLE.
//   - col == IMAGE_COLUMNS-1 with tlast=1: col := 0; row += 1.
//     If row == IMAGE_ROWS-1: row := 0, pulse frame_done (aligned with the last write), -> IDLE.
//  frame_done_o and sync_error_o are never asserted in the same cycle.
//  Single-pixel lines: tuser and tlast together are legal only when IMAGE_COLUMNS == 1.
//  Reset mid-frame: partial frame abandoned; no pulses; next frame requires tuser.
//  Counter widths use clogb2(N-1). All comparisons are unsigned; decode output is signed.
// CONFIGURATION
//  VIDEO_CAPTURE_FRAME_COUNT_EN defined:
//   - Adds port frame_count_o out 16: completed-frame count.
//   - Resets to 0, increments on frame_done_o, wraps 16'hFFFF -> 0.
//  Not defined: the port and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package video_stream_pkg:
//   - clogb2 function; FSM state enum (IDLE, CAPTURE).
//   - RGB field offsets (22/12/2); threshold 8'h80.
//   - pixel_pos_one/pixel_neg_one constants parameterised by bitdepth/frac.
//  Sub-module video_pixel_decode: combinational tdata -> signed sample.
//   - Shared with the generator's encoder tests.
// TESTING
//  1. Full 160x160 frame, first beat tuser, EOL every 160 beats
//     -> 25600 writes; row 159, col 159 last; frame_done pulses once.
//  2. tdata 32'h3FCFF3FC / 32'h3FC00000 / 0 -> mem_write_data_o 16'h0100 / 16'hFF00 / 16'h0000.
//  3. 50 beats before the first tuser -> no writes, no errors; capture starts at the tuser beat.
//  4. tlast at col 99 of row 5 -> write at (5,99), sync_error pulse, IDLE.
//     Next tuser restarts at (0,0).
//  5. tuser at row 80, col 10 -> sync_error; that beat is written at (0,0); capture continues.
//  6. rst_ni low at row 40 -> outputs 0 asynchronously; released -> beats ignored until tuser.
//     With VIDEO_CAPTURE_FRAME_COUNT_EN, count = 0.

Source files
------------

// File: rtl/video_stream_pkg.sv
// Shared definitions for the video stream capture path: width helper, FSM states,
// RGB field layout and the fixed-point +/-1.0 sample constants.
package video_stream_pkg;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((value >> i) != 0) width = i + 1;
    end
    return width;
  endfunction

  typedef enum logic {
    ST_IDLE,
    ST_CAPTURE
  } capture_state_e;

  localparam int unsigned RGB_C2_LSB = 22;
  localparam int unsigned RGB_C1_LSB = 12;
  localparam int unsigned RGB_C0_LSB = 2;
  localparam logic [7:0]  RGB_THRESHOLD = 8'h80;

  function automatic logic [31:0] sample_mask(input int unsigned bitdepth);
    return (bitdepth >= 32) ? '1 : ((32'(1) << bitdepth) - 32'(1));
  endfunction

  function automatic logic [31:0] pixel_pos_one(input int unsigned bitdepth,
                                                input int unsigned frac);
    return (32'(1) << frac) & sample_mask(bitdepth);
  endfunction

  function automatic logic [31:0] pixel_neg_one(input int unsigned bitdepth,
                                                input int unsigned frac);
    return (32'(0) - (32'(1) << frac)) & sample_mask(bitdepth);
  endfunction

endpackage

// File: rtl/video_pixel_decode.sv
// Combinational RGB beat -> signed fixed-point sample; inverse of the generator's
// white (+1.0) / blue (-1.0) / black (0) colour encoding.
module video_pixel_decode
  import video_stream_pkg::*;
#(
  parameter int unsigned PIXEL_BITDEPTH        = 16,
  parameter int unsigned PIXEL_FRACTIONAL_SIZE = 8
) (
  input  logic [31:0]                      tdata_i,
  output logic signed [PIXEL_BITDEPTH-1:0] sample_o
);

  localparam logic [PIXEL_BITDEPTH-1:0] POS_ONE =
    PIXEL_BITDEPTH'(pixel_pos_one(PIXEL_BITDEPTH, PIXEL_FRACTIONAL_SIZE));
  localparam logic [PIXEL_BITDEPTH-1:0] NEG_ONE =
    PIXEL_BITDEPTH'(pixel_neg_one(PIXEL_BITDEPTH, PIXEL_FRACTIONAL_SIZE));

  logic [7:0] c2;
  logic [7:0] c1;
  logic       unused_bits;

  assign c2 = tdata_i[RGB_C2_LSB +: 8];
  assign c1 = tdata_i[RGB_C1_LSB +: 8];
  // C0 and the padding bits carry no information for the three legal colours
  assign unused_bits = ^{tdata_i[31:30], tdata_i[21:20], tdata_i[11:0]};

  always_comb begin
    sample_o = '0;
    if (c1 >= RGB_THRESHOLD) begin
      sample_o = POS_ONE;
    end else if (c2 >= RGB_THRESHOLD) begin
      sample_o = NEG_ONE;
    end
  end

endmodule

// File: rtl/video_stream_capture.sv
// AXI4-Stream video slave writing decoded pixels into per-column frame memories.
// Optional completed-frame counter port frame_count_o: define VIDEO_CAPTURE_FRAME_COUNT_EN.
module video_stream_capture
  import video_stream_pkg::*;
#(
  parameter int unsigned PIXEL_BITDEPTH        = 16,
  parameter int unsigned PIXEL_FRACTIONAL_SIZE = 8,
  parameter int unsigned IMAGE_COLUMNS         = 160,
  parameter int unsigned IMAGE_ROWS            = 160
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 s00_axis_tvalid,
  input  logic [31:0]                          s00_axis_tdata,
  input  logic                                 s00_axis_tlast,
  input  logic                                 s00_axis_tuser,
  output logic                                 s00_axis_tready,
  output logic [IMAGE_COLUMNS-1:0]             mem_write_en_o,
  output logic [clogb2(IMAGE_ROWS-1)-1:0]      mem_write_address_o,
  output logic signed [PIXEL_BITDEPTH-1:0]     mem_write_data_o,
  output logic                                 frame_done_o,
  output logic                                 sync_error_o
`ifdef VIDEO_CAPTURE_FRAME_COUNT_EN
  ,
  output logic [15:0]                          frame_count_o
`endif
);

  localparam int unsigned RW = clogb2(IMAGE_ROWS - 1);
  localparam int unsigned CW = clogb2(IMAGE_COLUMNS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_COLUMNS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_ROWS - 1);

  capture_state_e                    state_q, state_d;
  logic [RW-1:0]                     row_q, row_d, row_eff;
  logic [CW-1:0]                     col_q, col_d, col_eff;
  logic                              tready_q;
  logic [IMAGE_COLUMNS-1:0]          wr_en_q, wr_en_d;
  logic [RW-1:0]                     wr_addr_q, wr_addr_d;
  logic signed [PIXEL_BITDEPTH-1:0]  wr_data_q, wr_data_d, sample;
  logic                              frame_done_q, frame_done_d;
  logic                              sync_error_q, sync_error_d;
  logic                              accept, sof, capture;

  video_pixel_decode #(
    .PIXEL_BITDEPTH       (PIXEL_BITDEPTH),
    .PIXEL_FRACTIONAL_SIZE(PIXEL_FRACTIONAL_SIZE)
  ) u_decode (
    .tdata_i (s00_axis_tdata),
    .sample_o(sample)
  );

  assign accept = s00_axis_tvalid & tready_q;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    wr_en_d      = '0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    sync_error_d = 1'b0;
    sof          = accept & s00_axis_tuser;
    capture      = accept & (sof | (state_q == ST_CAPTURE));
    // An SOF beat from either state is handled as pixel (0,0), so the line/frame
    // end checks below apply uniformly to it.
    row_eff      = sof ? '0 : row_q;
    col_eff      = sof ? '0 : col_q;

    if (sof && (state_q == ST_CAPTURE)) sync_error_d = 1'b1;

    if (capture) begin
      wr_en_d   = IMAGE_COLUMNS'(1) << col_eff;
      wr_addr_d = row_eff;
      wr_data_d = sample;
      state_d   = ST_CAPTURE;
      row_d     = row_eff;
      col_d     = col_eff + 1'b1;
      if (col_eff == COL_LAST) begin
        col_d = '0;
        if (!s00_axis_tlast) begin
          sync_error_d = 1'b1;
          row_d        = '0;
          state_d      = ST_IDLE;
        end else if (row_eff == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          row_d = row_eff + 1'b1;
        end
      end else if (s00_axis_tlast) begin
        sync_error_d = 1'b1;
        row_d        = '0;
        col_d        = '0;
        state_d      = ST_IDLE;
      end
    end
  end

`ifdef VIDEO_CAPTURE_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb frame_count_d = frame_count_q + 16'(frame_done_d);

  assign frame_count_o = frame_count_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      tready_q      <= 1'b0;
      wr_en_q       <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      sync_error_q  <= 1'b0;
`ifdef VIDEO_CAPTURE_FRAME_COUNT_EN
      frame_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      tready_q      <= 1'b1;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      sync_error_q  <= sync_error_d;
`ifdef VIDEO_CAPTURE_FRAME_COUNT_EN
      frame_count_q <= frame_count_d;
`endif
    end
  end

  assign s00_axis_tready     = tready_q;
  assign mem_write_en_o      = wr_en_q;
  assign mem_write_address_o = wr_addr_q;
  assign mem_write_data_o    = wr_data_q;
  assign frame_done_o        = frame_done_q;
  assign sync_error_o        = sync_error_q;

endmodule

// File: tb/tb_video_stream_capture.sv
// Directed/randomised bench for video_stream_capture against a pixel-index reference model.
module tb_video_stream_capture;

  localparam int C  = 160;
  localparam int R  = 160;
  localparam int BD = 16;
  localparam int AW = 8;

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b0;
  logic          tvalid = 1'b0;
  logic          tlast  = 1'b0;
  logic          tuser  = 1'b0;
  logic [31:0]   tdata  = '0;
  logic          tready;
  logic [C-1:0]  wr_en;
  logic [AW-1:0] wr_addr;
  logic [BD-1:0] wr_data;
  logic          done;
  logic          err;
`ifdef VIDEO_CAPTURE_FRAME_COUNT_EN
  logic [15:0]   fcount;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: whether a frame is open and the linear index of the next pixel
  bit in_frame = 1'b0;
  int k_next   = 0;

  // observations accumulated per phase
  int n_wr, n_err, n_done, last_row, last_col;

  always #5 clk_i = ~clk_i;

  video_stream_capture #(
    .PIXEL_BITDEPTH       (BD),
    .PIXEL_FRACTIONAL_SIZE(8),
    .IMAGE_COLUMNS        (C),
    .IMAGE_ROWS           (R)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .s00_axis_tvalid    (tvalid),
    .s00_axis_tdata     (tdata),
    .s00_axis_tlast     (tlast),
    .s00_axis_tuser     (tuser),
    .s00_axis_tready    (tready),
    .mem_write_en_o     (wr_en),
    .mem_write_address_o(wr_addr),
    .mem_write_data_o   (wr_data),
    .frame_done_o       (done),
    .sync_error_o       (err)
`ifdef VIDEO_CAPTURE_FRAME_COUNT_EN
    ,
    .frame_count_o      (fcount)
`endif
  );

  task automatic chk(input string tag, input logic [C-1:0] obs, input logic [C-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BD-1:0] ref_sample(input logic [31:0] d);
    int c2;
    int c1;
    int one;
    c2  = int'(d[29:22]);
    c1  = int'(d[19:12]);
    one = 1 << 8;
    if (c1 >= 128) return BD'(one);
    if (c2 >= 128) return BD'(-one);
    return '0;
  endfunction

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 32'h3FCFF3FC;
      1:       return 32'h3FC00000;
      2:       return 32'h00000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic clear_obs();
    n_wr = 0; n_err = 0; n_done = 0; last_row = -1; last_col = -1;
  endtask

  task automatic beat(input bit v, input bit u, input bit l, input logic [31:0] d);
    bit           ew;
    bit           edn;
    bit           eer;
    int           er;
    int           ec;
    logic [BD-1:0] ed;
    logic [C-1:0]  ee;
    ew = 1'b0; edn = 1'b0; eer = 1'b0; er = 0; ec = 0; ed = '0; ee = '0;
    @(negedge clk_i);
    tvalid = v; tuser = u; tlast = l; tdata = d;
    if (v && u) begin
      eer      = in_frame;
      in_frame = 1'b1;
      k_next   = 0;
    end
    if (v && in_frame) begin
      er = k_next / C;
      ec = k_next % C;
      ew = 1'b1;
      ed = ref_sample(d);
      if (ec == C - 1 && l) begin
        k_next++;
        if (k_next == R * C) begin
          edn = 1'b1; in_frame = 1'b0; k_next = 0;
        end
      end else if (ec == C - 1 || l) begin
        eer = 1'b1; in_frame = 1'b0; k_next = 0;
      end else begin
        k_next++;
      end
    end
    if (ew) ee[ec] = 1'b1;
    @(posedge clk_i);
    #1;
    chk("tready", tready, 1);
    chk("wr_en", wr_en, ee);
    if (ew) begin
      chk("wr_addr", wr_addr, er);
      chk("wr_data", wr_data, ed);
    end
    chk("frame_done", done, edn);
    chk("sync_error", err, eer);
    if (wr_en != '0) begin
      n_wr++;
      last_row = int'(wr_addr);
      for (int i = 0; i < C; i++) if (wr_en[i]) last_col = i;
    end
    n_err  += int'(err);
    n_done += int'(done);
  endtask

  task automatic send_pixel(input bit u, input bit l);
    if ($urandom_range(0, 7) == 0) beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    beat(1'b1, u, l, pick_data());
  endtask

  task automatic run_pixels(input int from_k, input int to_k);
    for (int k = from_k; k < to_k; k++) send_pixel(k == 0, (k % C) == C - 1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tready"}, tready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
`ifdef VIDEO_CAPTURE_FRAME_COUNT_EN
    chk({tag, "_fcount"}, fcount, 0);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("tready_after_reset", tready, 1);

    // beats before any SOF are dropped silently
    clear_obs();
    repeat (50) beat(1'b1, 1'b0, 1'($urandom_range(0, 1)), pick_data());
    chk("pre_sof_writes", n_wr, 0);
    chk("pre_sof_errors", n_err, 0);

    // one complete frame
    clear_obs();
    run_pixels(0, C * R);
    chk("frame_writes", n_wr, C * R);
    chk("frame_done_count", n_done, 1);
    chk("frame_errors", n_err, 0);
    chk("frame_last_row", last_row, R - 1);
    chk("frame_last_col", last_col, C - 1);
`ifdef VIDEO_CAPTURE_FRAME_COUNT_EN
    chk("frame_count_one", fcount, 1);
`endif

    // decode of the three legal colours
    clear_obs();
    beat(1'b1, 1'b1, 1'b0, 32'h3FCFF3FC);
    chk("decode_white", wr_data, 16'h0100);
    chk("sof_row", last_row, 0);
    chk("sof_col", last_col, 0);
    beat(1'b1, 1'b0, 1'b0, 32'h3FC00000);
    chk("decode_blue", wr_data, 16'hFF00);
    beat(1'b1, 1'b0, 1'b0, 32'h00000000);
    chk("decode_black", wr_data, 16'h0000);

    // early EOL at row 5, column 99
    run_pixels(3, 5 * C + 99);
    clear_obs();
    beat(1'b1, 1'b0, 1'b1, pick_data());
    chk("early_eol_error", n_err, 1);
    chk("early_eol_row", last_row, 5);
    chk("early_eol_col", last_col, 99);
    clear_obs();
    repeat (5) beat(1'b1, 1'b0, 1'b0, pick_data());
    chk("after_eol_writes", n_wr, 0);
    chk("after_eol_errors", n_err, 0);

    // mid-frame SOF at row 80, column 10 restarts the frame
    clear_obs();
    run_pixels(0, 80 * C + 10);
    chk("pre_resync_errors", n_err, 0);
    chk("pre_resync_row", last_row, 80);
    chk("pre_resync_col", last_col, 9);
    clear_obs();
    beat(1'b1, 1'b1, 1'b0, pick_data());
    chk("resync_error", n_err, 1);
    chk("resync_writes", n_wr, 1);
    chk("resync_row", last_row, 0);
    chk("resync_col", last_col, 0);
    run_pixels(1, 40 * C + 5);

    // asynchronous reset mid-frame
    #2;
    rst_ni = 1'b0;
    tvalid = 1'b0;
    in_frame = 1'b0;
    k_next = 0;
    #1;
    chk_outputs_zero("async_reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("tready_after_rerelease", tready, 1);
    clear_obs();
    repeat (20) beat(1'b1, 1'b0, 1'($urandom_range(0, 1)), pick_data());
    chk("post_reset_writes", n_wr, 0);
    chk("post_reset_errors", n_err, 0);
    clear_obs();
    beat(1'b1, 1'b1, 1'b0, pick_data());
    chk("post_reset_sof_writes", n_wr, 1);
    chk("post_reset_sof_row", last_row, 0);
    chk("post_reset_sof_col", last_col, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
